// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO bus initiator and its request queue.
// The two addresses are where io_block maps its LED and switch registers.
package io_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        RESP
    } io_state_e;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } io_req_t;

    localparam logic [7:0] IO_LED_ADDR = 8'h00;
    localparam logic [7:0] IO_SW_ADDR  = 8'h04;

endpackage

// File: rtl/io_req_fifo.sv
// In-order request queue for io_bus_master; pointers wrap naturally and an
// occupancy count one bit wider than the pointers distinguishes full from empty.
module io_req_fifo
    import io_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  io_req_t push_data,
    input  logic    pop,
    output io_req_t pop_data,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    io_req_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state is written only with <= so every flop samples the
    // pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assert property (@(posedge clk) disable iff (!reset_n) !(push && full));

endmodule

// File: rtl/io_bus_master.sv
// Initiator for io_block: queues core load/store requests and replays them in
// order as single-cycle write_en/read_en strobes, returning read data.
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic [7:0] addr,
    output logic [7:0] write_data,
    output logic       write_en,
    output logic       read_en,
    input  logic [7:0] read_data,
    output logic       busy
);

    io_state_e  state;
    io_state_e  next_state;
    io_req_t    push_req;
    io_req_t    head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       capture;
    logic [2:0] lat_cnt;

    assign req_ready = reset_n && !fifo_full;
    assign push      = req_valid && req_ready;
    assign push_req  = '{write: req_write, addr: req_addr, wdata: req_wdata};

    // A response handshake frees the bus in the same cycle, so RESP can pop
    // just like IDLE and WRITE do.
    assign pop = !fifo_empty &&
                 ((state == IDLE) || (state == WRITE) ||
                  ((state == RESP) && rsp_ready));

    assign capture = (state == WAIT) && (lat_cnt == 3'd1);

    io_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, WRITE: next_state = IDLE;
            READ:        next_state = WAIT;
            WAIT:        if (capture) next_state = RESP;
            RESP:        if (rsp_ready) next_state = IDLE;
            default:     next_state = IDLE;
        endcase
        if (pop) next_state = head.write ? WRITE : READ;
    end

    always_comb begin
        write_en  = (state == WRITE);
        read_en   = (state == READ);
        rsp_valid = (state == RESP);
        busy      = !fifo_empty || (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr       <= 8'h00;
            write_data <= 8'h00;
            rsp_rdata  <= 8'h00;
            lat_cnt    <= 3'd0;
        end else begin
            if (pop) begin
                addr <= head.addr;
                if (head.write) write_data <= head.wdata;
            end
            if (state == READ)      lat_cnt <= 3'(READ_LATENCY);
            else if (state == WAIT) lat_cnt <= lat_cnt - 1'b1;
            if (capture) rsp_rdata <= read_data;
        end
    end

    assert property (@(posedge clk) disable iff (!reset_n) !(write_en && read_en));
    assert property (@(posedge clk) disable iff (!reset_n)
                     (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata)));

endmodule
